// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: instruction layout, opcode and
// condition encodings, flag bit positions and the stage FSM state type.
package alu_pkg;

  localparam int DATA_W    = 32;
  localparam int REG_IDX_W = 4;

  // Instruction field positions
  localparam int F_COND_HI = 31;
  localparam int F_COND_LO = 28;
  localparam int F_OP_HI   = 27;
  localparam int F_OP_LO   = 24;
  localparam int F_S       = 23;
  localparam int F_I       = 22;
  localparam int F_RD_HI   = 21;
  localparam int F_RD_LO   = 18;
  localparam int F_RN_HI   = 17;
  localparam int F_RN_LO   = 14;
  localparam int F_RM_HI   = 13;
  localparam int F_RM_LO   = 10;

  // Flag bit indices within {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Opcodes with special meaning to this stage; everything else is passed
  // straight to the ALU and written back normally.
  localparam logic [3:0] OP_CMP     = 4'b1011;
  localparam logic [3:0] OP_RSVD_LO = 4'b1100;
  localparam logic [3:0] OP_RSVD_HI = 4'b1111;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  function automatic logic op_is_reserved(input logic [3:0] op);
    return (op >= OP_RSVD_LO) && (op <= OP_RSVD_HI);
  endfunction

endpackage

// File: rtl/alu_issue_stage_cond_eval.sv
// Condition-code evaluator: decides whether an instruction executes given
// its 4-bit condition field and the architectural NZCV flags.
module cond_eval
  import alu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Full 16-way decode of the condition field
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-and-issue stage in front of the master ALU. Owns the register file
// and the NZCV flags; one instruction in flight, four cycles per instruction.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | in_ready high; latch instruction on in_valid
//   READ    | read Rn/Rm, build immediate, evaluate condition
//   EXEC    | ALU inputs stable; sample ALU result/flags at end of cycle
//   WB      | wb_valid/illegal visible; regfile/flags commit at end
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int IMM_W = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic [31:0] alu_reg1,
  output logic [31:0] alu_reg2,
  output logic [15:0] alu_iv,
  output logic [3:0]  alu_opcode,
  output logic [3:0]  alu_cond,
  output logic        alu_s,
  output logic [3:0]  alu_flag,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_new_flag,
  output logic [3:0]  flags,
  output logic        wb_valid,
  output logic [3:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        illegal,
  output logic        busy
);

  state_e state_q, state_d;
  logic   accept;

  logic [31:0] instr_q;
  logic [31:0] rf_q [NREGS];
  logic [3:0]  flags_q;

  logic [31:0] reg1_q, reg2_q;
  logic [15:0] iv_q;
  logic [3:0]  opcode_q, cond_q, alu_flag_q;
  logic        s_q, cond_pass_q;

  logic        wb_valid_q, illegal_q, flag_upd_q;
  logic [3:0]  wb_rd_q, new_flag_q;
  logic [31:0] wb_data_q;

  logic [3:0]       cond_f, op_f, rd_f, rn_f, rm_f;
  logic             s_f, i_f;
  logic [IMM_W-1:0] imm_f;
  logic             cond_pass_w;
  logic             rsvd_w, wb_en_w, flag_en_w;

  assign cond_f = instr_q[F_COND_HI:F_COND_LO];
  assign op_f   = instr_q[F_OP_HI:F_OP_LO];
  assign s_f    = instr_q[F_S];
  assign i_f    = instr_q[F_I];
  assign rd_f   = instr_q[F_RD_HI:F_RD_LO];
  assign rn_f   = instr_q[F_RN_HI:F_RN_LO];
  assign rm_f   = instr_q[F_RM_HI:F_RM_LO];
  assign imm_f  = instr_q[IMM_W-1:0];

  // Flags as they stand in READ; the previous WB has always committed by then
  cond_eval u_cond_eval (
    .cond  (cond_f),
    .flags (flags_q),
    .pass  (cond_pass_w)
  );

  // Next-state logic; acceptance only happens in IDLE
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = ST_READ;
        end
      end
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Instruction latch on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instr_q <= '0;
    else if (accept) instr_q <= in_instr;
  end

  // ALU operand registers, loaded in READ and held until the next READ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg1_q      <= '0;
      reg2_q      <= '0;
      iv_q        <= '0;
      opcode_q    <= '0;
      cond_q      <= '0;
      s_q         <= 1'b0;
      alu_flag_q  <= '0;
      cond_pass_q <= 1'b0;
    end else if (state_q == ST_READ) begin
      reg1_q      <= rf_q[rn_f];
      reg2_q      <= i_f ? 32'h0 : rf_q[rm_f];
      iv_q        <= i_f ? 16'(imm_f) : 16'h0;
      opcode_q    <= op_f;
      cond_q      <= cond_f;
      s_q         <= s_f;
      alu_flag_q  <= flags_q;
      cond_pass_q <= cond_pass_w;
    end
  end

  assign rsvd_w    = op_is_reserved(opcode_q);
  assign wb_en_w   = cond_pass_q && (opcode_q != OP_CMP) && !rsvd_w;
  assign flag_en_w = cond_pass_q && (s_q || (opcode_q == OP_CMP)) && !rsvd_w;

  // Capture the ALU outputs at the end of EXEC; pulses live only during WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      flag_upd_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      new_flag_q <= '0;
    end else if (state_q == ST_EXEC) begin
      wb_valid_q <= wb_en_w;
      illegal_q  <= rsvd_w;
      flag_upd_q <= flag_en_w;
      wb_rd_q    <= rd_f;
      wb_data_q  <= alu_result;
      new_flag_q <= alu_new_flag;
    end else begin
      wb_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      flag_upd_q <= 1'b0;
    end
  end

  // Architectural state commit at the end of WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      flags_q <= '0;
    end else begin
      if (wb_valid_q) rf_q[wb_rd_q] <= wb_data_q;
      if (flag_upd_q) flags_q <= new_flag_q;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign alu_reg1   = reg1_q;
  assign alu_reg2   = reg2_q;
  assign alu_iv     = iv_q;
  assign alu_opcode = opcode_q;
  assign alu_cond   = cond_q;
  assign alu_s      = s_q;
  assign alu_flag   = alu_flag_q;
  assign flags      = flags_q;
  assign wb_valid   = wb_valid_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign illegal    = illegal_q;

endmodule
